uart_memory_client: RTL and testbench

Host-side initiator for the UART memory protocol: turns a parallel read/write request into the byte sequence command, count, address-high, address-low (then data bytes for writes). It drives the `uart` transmitter and collects the single read-response byte from the `uart` receiver. It sits between on-chip test logic and a `uart` instance whose serial line faces a remote memory controller.

---
 rtl/uart_memory_client_pkg.sv | 29 ++
 rtl/uart_memory_client_if.sv | 36 +++
 rtl/uart_byte_issuer.sv | 36 +++
 rtl/uart_memory_client.sv | 161 ++++++++++++++++
 tb/tb_uart_memory_client.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_memory_client_pkg.sv
// Shared definitions for the UART memory protocol initiator: command codes,
// FSM state encoding and the latched request record.
package uart_memory_pkg;

    // Command codes understood by the remote memory controller.
    localparam logic [7:0] COMMAND_READ  = 8'h01;
    localparam logic [7:0] COMMAND_WRITE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_SEND_COUNT,
        ST_SEND_ADDR_HI,
        ST_SEND_ADDR_LO,
        ST_SEND_DATA,
        ST_WAIT_RESP
    } state_e;

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [7:0]  count;
    } request_t;

    function automatic logic [7:0] command_byte(input logic write);
        return write ? COMMAND_WRITE : COMMAND_READ;
    endfunction

endpackage

// File: rtl/uart_memory_client_if.sv
// Request, write-data, read-result and UART-side signals of uart_memory_client.
// The client itself uses the slave view; test logic plus the UART use master.
interface uart_memory_client_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_count;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_error;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        is_transmitting;
    logic        received;
    logic [7:0]  rx_byte;

    modport slave (
        input  req_valid, req_write, req_addr, req_count,
        input  wr_valid, wr_data,
        input  is_transmitting, received, rx_byte,
        output req_ready, wr_ready, rd_valid, rd_data, rd_error,
        output transmit, tx_byte
    );

    modport master (
        output req_valid, req_write, req_addr, req_count,
        output wr_valid, wr_data,
        output is_transmitting, received, rx_byte,
        input  req_ready, wr_ready, rd_valid, rd_data, rd_error,
        input  transmit, tx_byte
    );
endinterface

// File: rtl/uart_byte_issuer.sv
// Registers the one-cycle transmit pulse and its byte, and reports when the UART
// transmitter may take another byte.
module uart_byte_issuer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_i,
    input  logic [7:0] byte_i,
    input  logic       is_transmitting_i,
    output logic       free_o,
    output logic       transmit_o,
    output logic [7:0] tx_byte_o
);
    logic       transmit_q;
    logic [7:0] tx_byte_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            transmit_q <= issue_i;
            if (issue_i) begin
                tx_byte_q <= byte_i;
            end
        end
    end

    // The pulse register doubles as the guard: the UART raises its busy flag a
    // cycle after seeing the pulse, so that cycle must not count as free.
    assign free_o     = !is_transmitting_i && !transmit_q;
    assign transmit_o = transmit_q;
    assign tx_byte_o  = tx_byte_q;

endmodule

// File: rtl/uart_memory_client.sv
// Host-side initiator for the UART memory protocol: serialises read/write requests
// into command, count, address and data bytes. Optional macro: RESPONSE_TIMEOUT_EN.
module uart_memory_client
    import uart_memory_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_memory_client_if.slave bus
);
    state_e     state_q, state_d;
    request_t   req_q, req_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_error_q;
    logic       timer_expired;
    logic       issue;
    logic [7:0] issue_byte;
    logic       tx_free;
    logic       wr_ready_c;

    uart_byte_issuer u_issuer (
        .clk              (clk),
        .rst_n            (rst_n),
        .issue_i          (issue),
        .byte_i           (issue_byte),
        .is_transmitting_i(bus.is_transmitting),
        .free_o           (tx_free),
        .transmit_o       (bus.transmit),
        .tx_byte_o        (bus.tx_byte)
    );

`ifdef RESPONSE_TIMEOUT_EN
    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TimerW-1:0] timer_q, timer_d;
    logic              rd_error_d;

    // Counts completed WAIT_RESP cycles; expiry is judged on the last one.
    assign timer_expired = (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        timer_d = '0;
        if (state_q == ST_WAIT_RESP && !timer_expired) begin
            timer_d = timer_q + TimerW'(1);
        end
    end

    // A response arriving on the expiry cycle takes priority over the error.
    assign rd_error_d = (state_q == ST_WAIT_RESP) && !bus.received && timer_expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            rd_error_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            rd_error_q <= rd_error_d;
        end
    end
`else
    assign timer_expired = 1'b0;
    assign rd_error_q    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can infer a latch.
        state_d    = state_q;
        req_d      = req_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        issue      = 1'b0;
        issue_byte = 8'h00;
        wr_ready_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    req_d.write = bus.req_write;
                    req_d.addr  = bus.req_addr;
                    req_d.count = (bus.req_count == 8'd0) ? 8'd1 : bus.req_count;
                    state_d     = ST_SEND_CMD;
                end
            end
            ST_SEND_CMD: begin
                if (tx_free) begin
                    issue      = 1'b1;
                    issue_byte = command_byte(req_q.write);
                    state_d    = ST_SEND_COUNT;
                end
            end
            ST_SEND_COUNT: begin
                if (tx_free) begin
                    issue      = 1'b1;
                    issue_byte = req_q.write ? req_q.count : 8'd1;
                    state_d    = ST_SEND_ADDR_HI;
                end
            end
            ST_SEND_ADDR_HI: begin
                if (tx_free) begin
                    issue      = 1'b1;
                    issue_byte = req_q.addr[15:8];
                    state_d    = ST_SEND_ADDR_LO;
                end
            end
            ST_SEND_ADDR_LO: begin
                if (tx_free) begin
                    issue      = 1'b1;
                    issue_byte = req_q.addr[7:0];
                    state_d    = req_q.write ? ST_SEND_DATA : ST_WAIT_RESP;
                end
            end
            ST_SEND_DATA: begin
                wr_ready_c = tx_free;
                if (tx_free && bus.wr_valid) begin
                    issue       = 1'b1;
                    issue_byte  = bus.wr_data;
                    req_d.count = req_q.count - 8'd1;
                    if (req_q.count == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_RESP: begin
                if (bus.received) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = bus.rx_byte;
                    state_d    = ST_IDLE;
                end else if (timer_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.wr_ready  = wr_ready_c;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_error  = rd_error_q;

endmodule

// File: tb/tb_uart_memory_client.sv
// Self-checking bench for uart_memory_client: a UART model records the wire and
// compares it with frames built from the protocol rules.
module tb_uart_memory_client;

`ifdef RESPONSE_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 20;
`else
    localparam int unsigned TB_TIMEOUT = 100000;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_memory_client_if bus ();

    uart_memory_client #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] wire_q[$];
    int         wire_cyc[$];
    logic [7:0] exp_wire[$];
    logic [7:0] wbuf[$];
    int         cyc = 0;
    int         busy_cnt = 0;
    int         overlap = 0;
    int         rd_pulses = 0;
    int         err_pulses = 0;
    int         rd_cyc = 0;
    int         err_cyc = 0;
    int         accept_cyc = 0;
    logic [7:0] rd_last = 8'h00;
    bit         hold_busy = 1'b0;

    // UART model: records every transmit pulse, stays busy a random number of
    // cycles afterwards, and logs read results and errors.
    initial begin
        bus.is_transmitting = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy_cnt > 0) busy_cnt--;
            if (bus.transmit === 1'b1) begin
                if (bus.is_transmitting) overlap++;
                wire_q.push_back(bus.tx_byte);
                wire_cyc.push_back(cyc);
                busy_cnt = int'($urandom_range(1, 4));
            end
            bus.is_transmitting = (busy_cnt > 0) || hold_busy;
            if (bus.rd_valid === 1'b1) begin
                rd_pulses++;
                rd_last = bus.rd_data;
                rd_cyc  = cyc;
            end
            if (bus.rd_error === 1'b1) begin
                err_pulses++;
                err_cyc = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s bound expired", tag);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx_idle();
        int g = 0;
        while ((bus.is_transmitting || bus.transmit) && g < 100) begin
            tick(1);
            g++;
        end
        if (g >= 100) fail_timeout("tx_idle");
    endtask

    task automatic wait_wire(input int n, input string tag);
        int g = 0;
        while (wire_q.size() < n && g < 300) begin
            tick(1);
            g++;
        end
        if (g >= 300) fail_timeout(tag);
    endtask

    task automatic compare_wire(input string tag, input int from);
        check({tag, "_len"}, wire_q.size(), exp_wire.size());
        for (int i = from; i < exp_wire.size(); i++) begin
            if (i < wire_q.size()) check($sformatf("%s_b%0d", tag, i - from), wire_q[i], exp_wire[i]);
        end
    endtask

    task automatic check_latency(input int base);
        if (wire_cyc.size() > base) check("cmd_latency", wire_cyc[base], accept_cyc + 1);
    endtask

    task automatic push_header(input bit write, input logic [15:0] addr, input logic [7:0] count);
        exp_wire.push_back(write ? 8'h02 : 8'h01);
        exp_wire.push_back(write ? ((count == 8'd0) ? 8'h01 : count) : 8'h01);
        exp_wire.push_back(addr[15:8]);
        exp_wire.push_back(addr[7:0]);
    endtask

    task automatic do_request(input bit write, input logic [15:0] addr, input logic [7:0] count);
        int g = 0;
        bus.req_write = write;
        bus.req_addr  = addr;
        bus.req_count = count;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && g < 100) begin
            tick(1);
            g++;
        end
        if (g >= 100) fail_timeout("req_accept");
        accept_cyc = cyc + 1;
        tick(1);
        bus.req_valid = 1'b0;
        check("req_ready_low", bus.req_ready, 1'b0);
    endtask

    task automatic respond(input logic [7:0] resp);
        int p;
        int rx_cyc;
        p = rd_pulses;
        bus.rx_byte  = resp;
        bus.received = 1'b1;
        rx_cyc = cyc;
        tick(1);
        bus.received = 1'b0;
        bus.rx_byte  = 8'($urandom);
        tick(3);
        check("rd_valid_pulses", rd_pulses, p + 1);
        check("rd_data", rd_last, resp);
        check("rd_valid_latency", rd_cyc, rx_cyc + 1);
        check("req_ready_after_rd", bus.req_ready, 1'b1);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [7:0] resp);
        int base;
        base = exp_wire.size();
        push_header(1'b0, addr, 8'h00);
        wait_tx_idle();
        do_request(1'b0, addr, 8'($urandom));
        wait_wire(exp_wire.size(), "rd_header_wait");
        check_latency(base);
        compare_wire("rd_frame", base);
        tick(int'($urandom_range(0, 4)));
        respond(resp);
    endtask

    // Leaves wr_valid as driven on the last cycle; the caller decides what follows.
    task automatic do_write(input logic [15:0] addr, input logic [7:0] count, input int feed_limit);
        int n;
        int idx = 0;
        int g = 0;
        n = (count == 8'd0) ? 1 : int'(count);
        if (feed_limit > n) feed_limit = n;
        push_header(1'b1, addr, count);
        for (int i = 0; i < feed_limit; i++) exp_wire.push_back(wbuf[i]);
        wait_tx_idle();
        do_request(1'b1, addr, count);
        while (idx < feed_limit && g < 1000) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.wr_valid = 1'b0;
            end else begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = wbuf[idx];
                if (bus.wr_ready) idx++;
            end
            tick(1);
            g++;
        end
        check("wr_feed_done", idx, feed_limit);
    endtask

    initial begin
        int         base;
        int         p;
        bit         seen_ready;
        logic [15:0] addr;
        logic [7:0]  n8;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_count = 8'h00;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'h00;
        bus.received  = 1'b0;
        bus.rx_byte   = 8'h00;

        tick(3);
        check("rst_transmit", bus.transmit, 1'b0);
        check("rst_tx_byte", bus.tx_byte, 8'h00);
        check("rst_wr_ready", bus.wr_ready, 1'b0);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_rd_error", bus.rd_error, 1'b0);
        check("rst_rd_data", bus.rd_data, 8'h00);
        rst_n = 1'b1;
        tick(1);
        check("rst_req_ready", bus.req_ready, 1'b1);

        // A response byte while idle must not produce a read result.
        bus.rx_byte  = 8'h5A;
        bus.received = 1'b1;
        tick(1);
        bus.received = 1'b0;
        tick(3);
        check("rx_idle_ignored", rd_pulses, 0);

        do_read(16'h1234, 8'hA5);

        base = exp_wire.size();
        wbuf = '{8'h11, 8'h22, 8'h33};
        do_write(16'h0010, 8'd3, 3);
        bus.wr_valid = 1'b0;
        wait_wire(exp_wire.size(), "wr3_wait");
        tick(2);
        check_latency(base);
        compare_wire("wr3_frame", base);
        check("wr3_req_ready", bus.req_ready, 1'b1);

        // Count 0 behaves as count 1; further offered bytes stay unconsumed.
        base = exp_wire.size();
        wbuf = '{8'hC3, 8'h3C};
        do_write(16'hA55A, 8'd0, 2);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hEE;
        seen_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.wr_ready) seen_ready = 1'b1;
            tick(1);
        end
        bus.wr_valid = 1'b0;
        check("wr0_no_extra_ready", seen_ready, 1'b0);
        compare_wire("wr0_frame", base);

        // Transmitter held busy after the command byte.
        base = exp_wire.size();
        push_header(1'b0, 16'hBEEF, 8'h00);
        wait_tx_idle();
        do_request(1'b0, 16'hBEEF, 8'h07);
        wait_wire(base + 1, "hold_cmd_wait");
        hold_busy = 1'b1;
        p = rd_pulses;
        for (int i = 0; i < 50; i++) begin
            bus.rx_byte  = 8'h77;
            bus.received = (i == 10);
            tick(1);
        end
        bus.received = 1'b0;
        check("hold_no_tx", wire_q.size(), base + 1);
        check("hold_rx_ignored", rd_pulses, p);
        hold_busy = 1'b0;
        wait_wire(base + 4, "hold_header_wait");
        compare_wire("hold_frame", base);
        respond(8'h3C);

        // Reset in the middle of the data phase.
        base = exp_wire.size();
        wbuf.delete();
        for (int i = 0; i < 6; i++) wbuf.push_back(8'($urandom));
        do_write(16'h4321, 8'd6, 2);
        bus.wr_valid = 1'b1;
        bus.wr_data  = wbuf[2];
        rst_n = 1'b0;
        #1;
        check("mid_rst_transmit", bus.transmit, 1'b0);
        check("mid_rst_tx_byte", bus.tx_byte, 8'h00);
        check("mid_rst_wr_ready", bus.wr_ready, 1'b0);
        check("mid_rst_rd_valid", bus.rd_valid, 1'b0);
        check("mid_rst_rd_data", bus.rd_data, 8'h00);
        check("mid_rst_rd_error", bus.rd_error, 1'b0);
        tick(2);
        rst_n = 1'b1;
        seen_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.wr_ready) seen_ready = 1'b1;
            tick(1);
        end
        bus.wr_valid = 1'b0;
        check("mid_rst_no_consume", seen_ready, 1'b0);
        check("mid_rst_req_ready", bus.req_ready, 1'b1);
        compare_wire("mid_rst_frame", base);

        // Randomised mix of reads and writes.
        for (int it = 0; it < 8; it++) begin
            addr = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                n8 = 8'($urandom_range(0, 5));
                wbuf.delete();
                for (int i = 0; i < 6; i++) wbuf.push_back(8'($urandom));
                base = exp_wire.size();
                do_write(addr, n8, 255);
                bus.wr_valid = 1'b0;
                wait_wire(exp_wire.size(), "rnd_wr_wait");
                tick(2);
                compare_wire("rnd_wr_frame", base);
            end else begin
                do_read(addr, 8'($urandom));
            end
        end

`ifdef RESPONSE_TIMEOUT_EN
        base = exp_wire.size();
        push_header(1'b0, 16'h0F0F, 8'h00);
        wait_tx_idle();
        p = rd_pulses;
        do_request(1'b0, 16'h0F0F, 8'h00);
        wait_wire(base + 4, "to_header_wait");
        n8 = 8'(err_pulses);
        tick(int'(TB_TIMEOUT) + 10);
        check("to_err_pulses", err_pulses, 32'(n8) + 1);
        check("to_no_rd_valid", rd_pulses, p);
        if (wire_cyc.size() > base + 3) check("to_err_cycle", err_cyc, wire_cyc[base + 3] + int'(TB_TIMEOUT));
`else
        check("rd_error_never", err_pulses, 0);
`endif
        check("no_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
